// File: rtl/db_multi_if.sv
// db_multi_if: raw switch inputs plus debounced levels, event ticks and the shared sample tick.
interface db_multi_if #(
   parameter int N = 2
);
   logic [N-1:0] sw;
   logic [N-1:0] db;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] long_tick;
   logic [N-1:0] rep_tick;
   logic         m_tick;
   modport master (output sw, input db, rise, fall, long_tick, rep_tick, m_tick);
   modport slave  (input sw, output db, rise, fall, long_tick, rep_tick, m_tick);
endinterface

// File: rtl/db_multi.sv
// db_multi: N-channel switch debouncer with edge, long-press and auto-repeat ticks on a shared sample prescaler.
module db_multi #(
   parameter int N            = 2,
   parameter int TICK_DIV     = 1_000_000,
   parameter int CONFIRM      = 3,
   parameter int LONG_TICKS   = 100,
   parameter int REPEAT_TICKS = 20
) (
   input logic       clk,
   input logic       reset,
   db_multi_if.slave bus
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = CONFIRM > 1 ? $clog2(CONFIRM) : 1;
   localparam int HW = $clog2(LONG_TICKS + 1);
   localparam int RT = REPEAT_TICKS > 0 ? REPEAT_TICKS : 1;
   localparam int RW = $clog2(RT + 1);

   typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

   logic [PW-1:0] pc;
   logic          tick;
   logic [N-1:0]  s1, s;
   state_t        st [N];
   state_t        nst [N];
   logic [CW-1:0] cnf [N];
   logic [CW-1:0] ncnf [N];
   logic [HW-1:0] hc [N];
   logic [RW-1:0] rc [N];
   logic [N-1:0]  cur_db, nxt_db, cnt, lng, rep;

   assign tick = pc == PW'(TICK_DIV - 1);
   assign bus.m_tick = tick;
   assign bus.db = cur_db;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         nst[i] = st[i];
         ncnf[i] = cnf[i];
         case (st[i])
            ZERO: if (s[i]) begin
               nst[i] = WAIT1;
               ncnf[i] = '0;
            end
            WAIT1: if (!s[i]) nst[i] = ZERO;
            else if (tick) begin
               if (cnf[i] == CW'(CONFIRM - 1)) nst[i] = ONE;
               else ncnf[i] = cnf[i] + 1'b1;
            end
            ONE: if (!s[i]) begin
               nst[i] = WAIT0;
               ncnf[i] = '0;
            end
            default: if (s[i]) nst[i] = ONE;
            else if (tick) begin
               if (cnf[i] == CW'(CONFIRM - 1)) nst[i] = ZERO;
               else ncnf[i] = cnf[i] + 1'b1;
            end
         endcase
         cur_db[i] = st[i] == ONE || st[i] == WAIT0;
         nxt_db[i] = nst[i] == ONE || nst[i] == WAIT0;
         // hold/repeat ticks only count while the press survives the tick, so nothing fires once db drops
         cnt[i] = tick && cur_db[i] && nxt_db[i];
         lng[i] = cnt[i] && hc[i] == HW'(LONG_TICKS - 1);
         rep[i] = REPEAT_TICKS != 0 && cnt[i] && hc[i] == HW'(LONG_TICKS) && rc[i] == RW'(RT - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= '0;
         s1 <= '0;
         s <= '0;
         bus.rise <= '0;
         bus.fall <= '0;
         bus.long_tick <= '0;
         bus.rep_tick <= '0;
         for (int i = 0; i < N; i++) begin
            st[i] <= ZERO;
            cnf[i] <= '0;
            hc[i] <= '0;
            rc[i] <= '0;
         end
      end else begin
         pc <= tick ? '0 : pc + 1'b1;
         s1 <= bus.sw;
         s <= s1;
         bus.rise <= nxt_db & ~cur_db;
         bus.fall <= cur_db & ~nxt_db;
         bus.long_tick <= lng;
         bus.rep_tick <= rep;
         for (int i = 0; i < N; i++) begin
            st[i] <= nst[i];
            cnf[i] <= ncnf[i];
            hc[i] <= st[i] == WAIT1 && nst[i] == ONE ? '0 :
                     cnt[i] && hc[i] != HW'(LONG_TICKS) ? hc[i] + 1'b1 : hc[i];
            rc[i] <= lng[i] || rep[i] ? '0 :
                     cnt[i] && hc[i] == HW'(LONG_TICKS) ? rc[i] + 1'b1 : rc[i];
         end
      end
   end
endmodule

// File: tb/tb_db_multi.sv
// tb_db_multi: directed vector table plus bounce and reset-mid-press sequences for db_multi.
module tb_db_multi;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   db_multi_if #(.N(2)) bus ();
   db_multi_if #(.N(2)) bus0 ();
   assign bus0.sw = bus.sw;

   db_multi #(.N(2), .TICK_DIV(4), .CONFIRM(3), .LONG_TICKS(5), .REPEAT_TICKS(2))
      dut (.clk(clk), .reset(reset), .bus(bus));
   db_multi #(.N(2), .TICK_DIV(4), .CONFIRM(3), .LONG_TICKS(5), .REPEAT_TICKS(0))
      dut0 (.clk(clk), .reset(reset), .bus(bus0));

   typedef struct {
      logic [1:0]  sw;
      int          len;
      logic [1:0]  db;
      logic [15:0] ev0;
      logic [15:0] ev1;
      int          at0;
      int          at1;
   } vec_t;

   int checks = 0, failures = 0, cyc = 0, mt_bad = 0, z_long = 0, z_rep = 0, k = 0;
   int n_rise [2], n_fall [2], n_long [2], n_rep [2], first_rise [2];
   vec_t tbl [12];

   task automatic clear();
      for (int i = 0; i < 2; i++) begin
         n_rise[i] = 0;
         n_fall[i] = 0;
         n_long[i] = 0;
         n_rep[i] = 0;
         first_rise[i] = -1;
      end
   endtask

   task automatic step();
      logic r;
      r = reset;
      @(posedge clk);
      #1;
      cyc = r ? 0 : cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (bus.rise[i]) begin
            n_rise[i]++;
            if (first_rise[i] < 0) first_rise[i] = cyc;
         end
         if (bus.fall[i]) n_fall[i]++;
         if (bus.long_tick[i]) n_long[i]++;
         if (bus.rep_tick[i]) n_rep[i]++;
      end
      if (bus.m_tick !== (cyc % 4 == 3)) mt_bad++;
      z_long += $countones(bus0.long_tick);
      z_rep += $countones(bus0.rep_tick);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic logic [15:0] ev(input int i);
      return {4'(n_rise[i]), 4'(n_fall[i]), 4'(n_long[i]), 4'(n_rep[i])};
   endfunction

   function automatic logic [21:0] outs();
      return {bus.db, bus.rise, bus.fall, bus.long_tick, bus.rep_tick, bus.m_tick,
              bus0.db, bus0.rise, bus0.fall, bus0.long_tick, bus0.rep_tick, bus0.m_tick};
   endfunction

   initial begin
      // ev nibbles: {rise, fall, long, rep}; at = cycle of first rise, -1 for none
      tbl[0]  = '{2'b00, 10, 2'b00, 16'h0000, 16'h0000, -1, -1};
      tbl[1]  = '{2'b01, 60, 2'b01, 16'h1013, 16'h0000, 24, -1};
      tbl[2]  = '{2'b00, 20, 2'b00, 16'h0101, 16'h0000, -1, -1};
      tbl[3]  = '{2'b11, 16, 2'b11, 16'h1000, 16'h1000, 104, 104};
      tbl[4]  = '{2'b01, 34, 2'b01, 16'h0012, 16'h0100, -1, -1};
      tbl[5]  = '{2'b00, 20, 2'b00, 16'h0101, 16'h0000, -1, -1};
      tbl[6]  = '{2'b01, 2,  2'b00, 16'h0000, 16'h0000, -1, -1};
      tbl[7]  = '{2'b00, 20, 2'b00, 16'h0000, 16'h0000, -1, -1};
      tbl[8]  = '{2'b10, 40, 2'b10, 16'h0000, 16'h1010, -1, 196};
      tbl[9]  = '{2'b00, 3,  2'b10, 16'h0000, 16'h0001, -1, -1};
      tbl[10] = '{2'b10, 30, 2'b10, 16'h0000, 16'h0003, -1, -1};
      tbl[11] = '{2'b00, 20, 2'b00, 16'h0000, 16'h0102, -1, -1};
      clear();
      bus.sw = 2'b00;
      repeat (3) step();
      check("reset_outs", 32'(outs()), 32'd0);
      reset = 1'b0;
      for (int t = 0; t < 12; t++) begin
         bus.sw = tbl[t].sw;
         clear();
         repeat (tbl[t].len) step();
         check($sformatf("v%0d_db", t), 32'(bus.db), 32'(tbl[t].db));
         check($sformatf("v%0d_ev0", t), 32'(ev(0)), 32'(tbl[t].ev0));
         check($sformatf("v%0d_ev1", t), 32'(ev(1)), 32'(tbl[t].ev1));
         check($sformatf("v%0d_rise_at", t), {first_rise[0][15:0], first_rise[1][15:0]},
               {tbl[t].at0[15:0], tbl[t].at1[15:0]});
      end
      check("norep_long_count", z_long, 3);
      clear();
      for (int p = 0; p < 10; p++) begin
         bus.sw = {1'b0, p % 2 == 0};
         repeat (3) step();
      end
      check("bounce_no_rise", n_rise[0], 0);
      check("bounce_db_low", 32'(bus.db), 32'd0);
      bus.sw = 2'b01;
      k = cyc;
      for (int w = 0; w < 20 && n_rise[0] == 0; w++) step();
      check_range("bounce_latency", first_rise[0] - (k + 1), 11, 14);
      repeat (4) step();
      check("bounce_one_rise", n_rise[0], 1);
      check("pre_reset_db", 32'(bus.db), 32'd1);
      clear();
      reset = 1'b1;
      step();
      check("midpress_reset_outs", 32'(outs()), 32'd0);
      reset = 1'b0;
      for (int w = 0; w < 20 && n_rise[0] == 0; w++) step();
      check_range("post_reset_latency", first_rise[0] - 1, 11, 14);
      check("post_reset_no_fall", n_fall[0], 0);
      check("mtick_grid_errors", mt_bad, 0);
      check("norep_rep_count", z_rep, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/db_multi.md
# db_multi

Parametrised N-channel switch debouncer with edge, long-press and auto-repeat event generation. It replaces the single-channel debounce FSM in the board-level button path. Raw, asynchronous, bouncing switch/button inputs enter the block. It emits clean levels and one-cycle event ticks, which feed counters, display logic and menu FSMs. All channels share one free-running sample-tick prescaler.

## Interface
- `N`, 2 — number of independent channels (≥1)
- `TICK_DIV`, 1_000_000 — clk cycles per sample tick (10 ms at 100 MHz); ≥2
- `CONFIRM`, 3 — consecutive ticks the input must stay at a new level before `db` changes; ≥1
- `LONG_TICKS`, 100 — ticks of continuous `db`=1 before `long_tick`; ≥1
- `REPEAT_TICKS`, 20 — ticks between `rep_tick` pulses after a long press; 0 disables repeat
- `clk` in 1 — system clock, all logic on rising edge
- `reset` in 1 — synchronous, active-high reset
- `sw` in N — raw switch inputs, asynchronous to `clk`
- `db` out N — debounced level per channel
- `rise` out N — one-cycle pulse on `db` 0→1
- `fall` out N — one-cycle pulse on `db` 1→0
- `long_tick` out N — one-cycle pulse when a press reaches `LONG_TICKS`
- `rep_tick` out N — one-cycle auto-repeat pulse while held past long press
- `m_tick` out 1 — shared sample tick (debug/observability)

## Operation
- Synchronizer: 2 flops per channel; `s[i]` is the second flop. All FSM decisions use `s[i]` only.
- Prescaler: counter `pc` cycles through 0..TICK_DIV-1 and wraps. `m_tick` = (`pc`==TICK_DIV-1), combinational from the register.
- Per-channel FSM, states ZERO, WAIT1, ONE, WAIT0; confirm counter `cnf`:
  - ZERO: if `s`=1, go to WAIT1 with `cnf`←0.
  - WAIT1: if `s`=0, go to ZERO. Otherwise, on `m_tick`: if `cnf`==CONFIRM-1, go to ONE; else `cnf`++.
  - ONE: if `s`=0, go to WAIT0 with `cnf`←0.
  - WAIT0: if `s`=1, go to ONE (hold count preserved). Otherwise, on `m_tick`: if `cnf`==CONFIRM-1, go to ZERO; else `cnf`++.
  - A `m_tick` coinciding with ZERO→WAIT1 or ONE→WAIT0 is not counted.
- `db` = state ∈ {ONE, WAIT0}, registered.
- `rise` is high in the first cycle `db`=1. `fall` is high in the first cycle `db`=0 after being 1. Both are registered, never high together, and never high in consecutive cycles for one channel.
- Hold counter `hc` (saturating, width clog2(LONG_TICKS+1)):
  - cleared on WAIT1→ONE;
  - increments on `m_tick` while `db`=1, including in WAIT0;
  - holds otherwise.
- `long_tick` pulses in the cycle after the tick on which `hc` becomes LONG_TICKS. It pulses once per press.
- Repeat counter `rc`:
  - cleared when `long_tick` fires;
  - increments on each subsequent `m_tick` while `db`=1.
  - When `rc` reaches REPEAT_TICKS, `rep_tick` pulses the next cycle and `rc`←0. Repeat continues until `db` falls.
  - With REPEAT_TICKS=0, `rep_tick` is constant 0.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.

## Timing
- Reset clears synchronizers, `pc`, `cnf`, `hc`, `rc` to 0 and all FSMs to ZERO. All outputs are 0 in the cycle after the reset edge.
- `sw` held high through reset release is treated as a new press: the channel goes through WAIT1, then `rise` fires.
- Reset mid-press or mid-confirm aborts with no `fall` pulse; `db` drops to 0 directly.
- Press latency is counted from the edge that first samples `sw`=1 to the edge setting `db`=1. It falls between (CONFIRM-1)·TICK_DIV+3 and CONFIRM·TICK_DIV+2 edges. Release latency is identical.
- A glitch shorter than the confirm window (any `s` reversal in WAIT1/WAIT0) produces no `db` change and no pulses.
- `long_tick` comes LONG_TICKS ticks after the rise, on tick-grid boundaries. The first `rep_tick` comes REPEAT_TICKS ticks after `long_tick`.
- Bounce during release (WAIT0→ONE) does not restart `hc` or `rc`.

## Test plan
Use N=2, TICK_DIV=4, CONFIRM=3, LONG_TICKS=5, REPEAT_TICKS=2 unless noted.

- Clean press: `sw[0]` 0→1, held 40 cycles → `db[0]` rises 11–14 edges after first sample, with exactly one `rise[0]`. `sw[1]` activity none.
- Bounce: `sw[0]` toggles every 3 cycles for 30 cycles, then settles at 1 → no `db`/`rise` during bounce. Single `rise` after settle, within 11–14 edges of last toggle.
- Long/repeat: `sw[0]` held 1 for 60 cycles → `long_tick` once, 5 ticks after `rise`. Then `rep_tick` every 8 cycles (2 ticks) until release. One `fall`, with no `rep_tick` after `db`=0.
- REPEAT_TICKS=0 rerun of the long/repeat scenario → `long_tick` once, `rep_tick` never.
- Simultaneous: both channels press on the same cycle → `rise[1:0]`=2'b11 in the same cycle. Release only ch1 → `fall`=2'b10, and ch0 long press unaffected.
- Reset mid-press: assert `reset` while `db[0]`=1 → next cycle all outputs 0 with no `fall`. With `sw[0]` still 1 after release, `rise[0]` fires 11–14 edges later.
